systolic_feeder: RTL
====================

# systolic_feeder

Operand feeder sitting directly upstream of the 3x3 fixed systolic array. It buffers one 3x3 matrix A and one 3x3 matrix B through a simple write port. On `start`, it clears the array, streams A columns and B rows into the array's `a1..a3` and `b1..b3` inputs for three cycles, zero-flushes the pipeline, and pulses `done` in the cycle the array's `c1..c9` outputs hold the final product. Row and column skew is applied inside the array, so the feeder emits unskewed data.

## Interface
- `data_size`, 8, operand width; matches the array's `data_size`.
- `FLUSH_CYCLES`, 4, number of zero-input cycles after the last stream step (2*(N-1) for N=3).
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  buffer write strobe.
- `wr_sel`  in  1  0 = matrix A buffer, 1 = matrix B buffer.
- `wr_addr`  in  4  element index row*3+col; valid range 0..8.
- `wr_data`  in  data_size  element value.
- `start`  in  1  begin a multiply; sampled only in IDLE.
- `a1`,`a2`,`a3`  out  data_size  to array rows 1..3.
- `b1`,`b2`,`b3`  out  data_size  to array columns 1..3.
- `array_clr`  out  1  drives the array's `reset` input.
- `busy`  out  1  high from the cycle after `start` is accepted through the `done` cycle.
- `done`  out  1  one-cycle pulse; `c1..c9` are final in this cycle.

## Operation
- Buffers: two arrays of 9 x data_size registers (A, B), cleared to 0 by `reset`.
- Writes: applied only when `wr_en=1`, `busy=0`, and `wr_addr<=8`. Addresses 9..15 are ignored. Writes while busy are dropped silently.
- FSM states: IDLE -> CLEAR -> STREAM -> FLUSH -> DONE -> IDLE.
  - IDLE: all outputs 0. `start=1` moves to CLEAR.
  - CLEAR: one cycle, `array_clr=1`.
  - STREAM: step counter k=0..2. Outputs are `a_i = A[i][k]` and `b_j = B[k][j]`, with i,j = 1..3. After k=2, go to FLUSH.
  - FLUSH: `FLUSH_CYCLES` cycles, a/b outputs 0.
  - DONE: one cycle, `done=1`; then IDLE.
- All outputs are registered. Reset values: a/b = 0, `array_clr`=0, `busy`=0, `done`=0, state = IDLE, k=0, flush counter=0.
- `start` outside IDLE is ignored; there is no queueing.
- `start` and `wr_en` in the same IDLE cycle: the write commits, and the stream uses the new value.
- `reset` mid-operation: next cycle is IDLE, all outputs 0, buffers cleared, and the in-flight multiply is abandoned.
- Arithmetic: the feeder performs none. The array accumulators are 2*data_size+1 bits and wrap modulo 2^(2*data_size+1). Callers are responsible for range.
- Buffers persist across runs. Re-issuing `start` without writes recomputes the same product.

## Timing
Let E0 be the edge that samples `start` in IDLE (with `SYSTOLIC_FEEDER_CLR_EN` defined):
- After E0: `array_clr=1`, `busy=1`.
- After E1, E2, E3: stream steps k=0, 1, 2.
- After E4..E7: zero flush.
- After E8: `done=1`, and `c9` has taken its last accumulate at E8.
- After E9: `done=0`, `busy=0`. `start` is accepted again from E9 onward.

Totals: start-to-done = 8 edges; busy spans 9 cycles.

## Configuration
- `SYSTOLIC_FEEDER_CLR_EN` defined: the CLEAR state is present, and `array_clr` pulses for one cycle before each stream.
- Macro undefined: no CLEAR state, and `array_clr` is tied to 0. The timeline shifts one cycle earlier (stream after E0..E2, `done` after E7), and the array accumulates across runs unless cleared externally.

## Test plan
- Reset check: hold `reset` 2 cycles -> all outputs 0 and state IDLE. Issue `start` after writing nothing -> a/b stream all zeros, `done` at E8, `c1..c9`=0.
- Identity multiply: A = [[1,2,3],[4,5,6],[7,8,9]], B = I, then `start` -> `a1` sequence 1,2,3; `b1` sequence 1,0,0; at `done`, `c1..c9` = 1..9.
- General product: A as above, B = A -> at `done`, `c1..c9` = 30,36,42,66,81,96,102,126,150. `busy` is high for exactly 9 cycles.
- Overflow wrap: all A and B elements = 255 -> every `c` = 195075 mod 131072 = 64003 at `done`.
- Busy lockout: pulse `start` and write A[0]=99 during STREAM -> the write is dropped, the second `start` is ignored, and a rerun still gives `c1`=30 (B = A case).
- Reset mid-run: assert `reset` after E2 -> next cycle all outputs 0, `busy`=0, buffers read back 0. A subsequent `start` yields all-zero `c`.

Source files
------------

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers a 3x3 A and B matrix and streams them,
// unskewed, into a 3x3 systolic array, then flushes and signals done.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset (FSM, outputs, buffers)
//   wr_en      buffer write strobe (ignored while busy)
//   wr_sel     0 = A buffer, 1 = B buffer
//   wr_addr    element index row*3+col (9..15 ignored)
//   wr_data    element value
//   start      begin a multiply (sampled only in IDLE)
//   a1..a3     array row operands, a_i = A[i][k]
//   b1..b3     array column operands, b_j = B[k][j]
//   array_clr  drives the array's reset input
//   busy       high from the cycle after start through the done cycle
//   done       one-cycle pulse, array results final in this cycle
//
// Build option
//   SYSTOLIC_FEEDER_CLR_EN  adds a CLEAR state pulsing array_clr
//                           before each stream; undefined ties it to 0.

module systolic_feeder #(
  parameter int data_size    = 8,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [3:0]           wr_addr,
  input  logic [data_size-1:0] wr_data,
  input  logic                 start,
  output logic [data_size-1:0] a1,
  output logic [data_size-1:0] a2,
  output logic [data_size-1:0] a3,
  output logic [data_size-1:0] b1,
  output logic [data_size-1:0] b2,
  output logic [data_size-1:0] b3,
  output logic                 array_clr,
  output logic                 busy,
  output logic                 done
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int VW = 6 * data_size;

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef SYSTOLIC_FEEDER_CLR_EN
    S_CLEAR,
`endif
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state_q;

  logic [1:0]    k_q;
  logic [FW-1:0] fl_q;

  logic [data_size-1:0] abuf_q [9];
  logic [data_size-1:0] bbuf_q [9];
  logic [data_size-1:0] abuf_d [9];
  logic [data_size-1:0] bbuf_d [9];

  logic [VW-1:0] out_q;
  logic          busy_q;
  logic          done_q;

  logic          wr_ok;
  logic [1:0]    ld_k;
  logic [VW-1:0] ld_vec;

`ifdef SYSTOLIC_FEEDER_CLR_EN
  logic clr_q;
  assign array_clr = clr_q;
`else
  assign array_clr = 1'b0;
`endif

  assign {a1, a2, a3, b1, b2, b3} = out_q;
  assign busy = busy_q;
  assign done = done_q;

  // Writes only land while idle; busy_q is low exactly in IDLE.
  assign wr_ok = wr_en && !busy_q && (wr_addr <= 4'd8);

  // Next buffer contents. Stream loads read these so that a write in
  // the same cycle as start is already visible to the first step.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      abuf_d[i] = abuf_q[i];
      bbuf_d[i] = bbuf_q[i];
      if (wr_ok && (wr_addr == 4'(i))) begin
        if (wr_sel) begin
          bbuf_d[i] = wr_data;
        end else begin
          abuf_d[i] = wr_data;
        end
      end
    end
  end

  // Step to load on the coming edge: next k while streaming,
  // otherwise the first step.
  assign ld_k = (state_q == S_STREAM) ? (k_q + 2'd1) : 2'd0;

  // a_i takes column k of A, b_j takes row k of B.
  always_comb begin
    ld_vec = '0;
    case (ld_k)
      2'd0: ld_vec = {abuf_d[0], abuf_d[3], abuf_d[6],
                      bbuf_d[0], bbuf_d[1], bbuf_d[2]};
      2'd1: ld_vec = {abuf_d[1], abuf_d[4], abuf_d[7],
                      bbuf_d[3], bbuf_d[4], bbuf_d[5]};
      2'd2: ld_vec = {abuf_d[2], abuf_d[5], abuf_d[8],
                      bbuf_d[6], bbuf_d[7], bbuf_d[8]};
      default: ld_vec = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      fl_q    <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SYSTOLIC_FEEDER_CLR_EN
      clr_q   <= 1'b0;
`endif
      for (int i = 0; i < 9; i++) begin
        abuf_q[i] <= '0;
        bbuf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 9; i++) begin
        abuf_q[i] <= abuf_d[i];
        bbuf_q[i] <= bbuf_d[i];
      end
      // Operands are zero except in stream steps.
      out_q  <= '0;
      done_q <= 1'b0;
`ifdef SYSTOLIC_FEEDER_CLR_EN
      clr_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
`ifdef SYSTOLIC_FEEDER_CLR_EN
            state_q <= S_CLEAR;
            clr_q   <= 1'b1;
`else
            state_q <= S_STREAM;
            k_q     <= 2'd0;
            out_q   <= ld_vec;
`endif
          end
        end
`ifdef SYSTOLIC_FEEDER_CLR_EN
        S_CLEAR: begin
          state_q <= S_STREAM;
          k_q     <= 2'd0;
          out_q   <= ld_vec;
        end
`endif
        S_STREAM: begin
          if (k_q == 2'd2) begin
            state_q <= S_FLUSH;
            fl_q    <= '0;
          end else begin
            k_q   <= k_q + 2'd1;
            out_q <= ld_vec;
          end
        end
        S_FLUSH: begin
          if (fl_q == FW'(FLUSH_CYCLES - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            fl_q <= fl_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          k_q     <= '0;
          fl_q    <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
